uarc_send_scheduler: RTL and testbench

- Arbitrates incoming UARC "send" requests from up to TOTAL_BUSES receiver buses and hands exactly one at a time to core0 as a pending interrupt.
- Uses rotating (round-robin) priority so that no single bus can starve the others.
- Generates the per-bus send acknowledges and latches the winning bus's data word.
- Holds that word until core0 accepts it. Sits between the receiver_* bus bundle and core0's interrupt and dstack-injection logic.

---
 rtl/uarc_send_scheduler.sv | 113 +++++++++++
 tb/tb_uarc_send_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uarc_send_scheduler.sv
// Round-robin arbiter that turns UARC receiver send requests into a single held
// interrupt for core0, acknowledging the winning bus and latching its data word.
module uarc_send_scheduler #(
    parameter int unsigned WORD_MAG    = 5,
    parameter int unsigned TOTAL_BUSES = 1,
    localparam int unsigned WORD_WIDTH = 1 << WORD_MAG
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [TOTAL_BUSES-1:0]            receiver_enable,
    input  logic [TOTAL_BUSES-1:0]            receiver_sends,
    input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
    output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
    input  logic                              mask_we,
    input  logic [TOTAL_BUSES-1:0]            mask_value,
    input  logic                              int_enable,
    output logic                              int_valid,
    output logic [WORD_WIDTH-1:0]             int_bus,
    output logic [WORD_WIDTH-1:0]             int_data,
    input  logic                              int_ack
);

    localparam int unsigned PTR_W = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         rr_q, rr_d;
    logic [TOTAL_BUSES-1:0]   mask_q;
    logic [TOTAL_BUSES-1:0]   acks_q, acks_d;
    logic                     valid_q, valid_d;
    logic [WORD_WIDTH-1:0]    bus_q, bus_d;
    logic [WORD_WIDTH-1:0]    data_q, data_d;

    logic [TOTAL_BUSES-1:0]   eligible;
    logic                     found;
    logic [31:0]              idx;
    logic [31:0]              win_idx;

    // Scan from rr_q upward with wraparound; the first eligible index wins.
    always_comb begin
        eligible = receiver_sends & receiver_enable & mask_q;
        found    = 1'b0;
        win_idx  = '0;
        idx      = '0;
        for (int unsigned k = 0; k < TOTAL_BUSES; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= TOTAL_BUSES) begin
                idx = idx - TOTAL_BUSES;
            end
            if (!found && 1'(eligible >> idx)) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        acks_d  = '0;
        valid_d = valid_q;
        bus_d   = bus_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (int_enable && found) begin
                    acks_d  = TOTAL_BUSES'(1) << win_idx;
                    data_d  = WORD_WIDTH'(receiver_datas >> (win_idx * WORD_WIDTH));
                    bus_d   = WORD_WIDTH'(win_idx);
                    valid_d = 1'b1;
                    state_d = HOLD;
                    rr_d    = (win_idx + 1 == TOTAL_BUSES) ? '0 : PTR_W'(win_idx + 1);
                end
            end
            HOLD: begin
                if (int_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            mask_q  <= '1;
            acks_q  <= '0;
            valid_q <= 1'b0;
            bus_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            acks_q  <= acks_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
            data_q  <= data_d;
            if (mask_we) begin
                mask_q <= mask_value;
            end
        end
    end

    assign receiver_send_acks = acks_q;
    assign int_valid          = valid_q;
    assign int_bus            = bus_q;
    assign int_data           = data_q;

endmodule

// File: tb/tb_uarc_send_scheduler.sv
// Self-checking bench for uarc_send_scheduler with four buses: table-driven vectors
// plus hand sequences, with a scoreboard checking each ack pulse's bus and data.
module tb_uarc_send_scheduler;

    localparam int NB = 4;

    logic           clk;
    logic           reset;
    logic [NB-1:0]  receiver_enable;
    logic [NB-1:0]  receiver_sends;
    logic [127:0]   receiver_datas;
    logic [NB-1:0]  receiver_send_acks;
    logic           mask_we;
    logic [NB-1:0]  mask_value;
    logic           int_enable;
    logic           int_valid;
    logic [31:0]    int_bus;
    logic [31:0]    int_data;
    logic           int_ack;

    logic [31:0]    datas [NB];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rst;
        logic [NB-1:0] sends;
        logic [NB-1:0] en;
        logic          mwe;
        logic [NB-1:0] mval;
        logic          ie;
        logic          ack;
        logic [NB-1:0] e_acks;
        logic          e_valid;
        logic [1:0]    e_bus;
    } vec_t;

    typedef struct {
        logic [1:0]  bus;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q [$];
    vec_t tbl [37];

    uarc_send_scheduler #(
        .WORD_MAG    (5),
        .TOTAL_BUSES (NB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .receiver_enable    (receiver_enable),
        .receiver_sends     (receiver_sends),
        .receiver_datas     (receiver_datas),
        .receiver_send_acks (receiver_send_acks),
        .mask_we            (mask_we),
        .mask_value         (mask_value),
        .int_enable         (int_enable),
        .int_valid          (int_valid),
        .int_bus            (int_bus),
        .int_data           (int_data),
        .int_ack            (int_ack)
    );

    assign receiver_datas = {datas[3], datas[2], datas[1], datas[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] b);
        exp_t e;
        e.bus  = b;
        e.data = datas[b];
        sb_q.push_back(e);
    endtask

    // Scoreboard: every ack pulse must match the oldest outstanding expected grant.
    always @(posedge clk) begin
        #1;
        if (receiver_send_acks != '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'(receiver_send_acks), 32'h0);
            end else begin
                exp_t e;
                logic [NB-1:0] oh;
                e  = sb_q.pop_front();
                oh = NB'(1) << e.bus;
                chk("sb_ack_onehot", 32'(receiver_send_acks), 32'(oh));
                chk("sb_int_bus", int_bus, 32'(e.bus));
                chk("sb_int_data", int_data, e.data);
                chk("sb_int_valid", 32'(int_valid), 32'h1);
            end
        end
    end

    initial begin
        int n;
        // rst sends en mwe mval ie ack | e_acks e_valid e_bus
        tbl[0]  = '{1, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h0, 0, 0};
        tbl[1]  = '{1, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h0, 0, 0};
        tbl[2]  = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h1, 1, 0};
        tbl[3]  = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h0, 1, 0};
        tbl[4]  = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[5]  = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 0, 4'h4, 1, 2};
        tbl[6]  = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[7]  = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 0, 4'h1, 1, 0};
        tbl[8]  = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[9]  = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 0, 4'h4, 1, 2};
        tbl[10] = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[11] = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 0, 4'h1, 1, 0};
        tbl[12] = '{0, 4'h5, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[13] = '{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl[14] = '{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl[15] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h2, 1, 1};
        tbl[16] = '{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1, 1};
        tbl[17] = '{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 4'h0, 1, 1};
        tbl[18] = '{0, 4'hF, 4'hF, 0, 4'h0, 0, 1, 4'h0, 0, 0};
        tbl[19] = '{0, 4'hF, 4'hF, 1, 4'h4, 0, 0, 4'h0, 0, 0};
        tbl[20] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h4, 1, 2};
        tbl[21] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[22] = '{0, 4'hF, 4'hF, 1, 4'hF, 1, 0, 4'h4, 1, 2};
        tbl[23] = '{0, 4'hF, 4'hF, 1, 4'h0, 1, 0, 4'h0, 1, 2};
        tbl[24] = '{0, 4'hF, 4'hF, 1, 4'hF, 1, 1, 4'h0, 0, 0};
        tbl[25] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h8, 1, 3};
        tbl[26] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[27] = '{0, 4'h3, 4'hE, 0, 4'h0, 1, 0, 4'h2, 1, 1};
        tbl[28] = '{0, 4'h3, 4'hE, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[29] = '{0, 4'h1, 4'hE, 0, 4'h0, 1, 0, 4'h0, 0, 0};
        tbl[30] = '{0, 4'h1, 4'hF, 0, 4'h0, 1, 0, 4'h1, 1, 0};
        tbl[31] = '{0, 4'h1, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[32] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h2, 1, 1};
        tbl[33] = '{1, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h0, 0, 0};
        tbl[34] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 4'h1, 1, 0};
        tbl[35] = '{0, 4'hF, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};
        tbl[36] = '{0, 4'h0, 4'hF, 0, 4'h0, 1, 1, 4'h0, 0, 0};

        for (int i = 0; i < NB; i++) datas[i] = 32'hC0DE_0000 + 32'(i);

        for (int i = 0; i < $size(tbl); i++) begin
            reset           = tbl[i].rst;
            receiver_sends  = tbl[i].sends;
            receiver_enable = tbl[i].en;
            mask_we         = tbl[i].mwe;
            mask_value      = tbl[i].mval;
            int_enable      = tbl[i].ie;
            int_ack         = tbl[i].ack;
            if (tbl[i].e_acks != '0) push(tbl[i].e_bus);
            cycle();
            chk($sformatf("row%0d_acks", i), 32'(receiver_send_acks), 32'(tbl[i].e_acks));
            chk($sformatf("row%0d_valid", i), 32'(int_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk($sformatf("row%0d_bus", i), int_bus, 32'(tbl[i].e_bus));
            if (tbl[i].rst) begin
                chk($sformatf("row%0d_rst_bus", i), int_bus, 32'h0);
                chk($sformatf("row%0d_rst_data", i), int_data, 32'h0);
            end
        end

        // Long hold on bus 3 while bus 1 waits.
        mask_we = 1'b0; int_ack = 1'b0; int_enable = 1'b1; receiver_enable = '1;
        datas[3] = 32'hDEADBEEF;
        receiver_sends = 4'b1000;
        push(2'd3);
        cycle();
        chk("hold_grant_acks", 32'(receiver_send_acks), 32'h8);
        receiver_sends = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk($sformatf("hold%0d_valid", c), 32'(int_valid), 32'h1);
            chk($sformatf("hold%0d_bus", c), int_bus, 32'h3);
            chk($sformatf("hold%0d_data", c), int_data, 32'hDEADBEEF);
            chk($sformatf("hold%0d_acks", c), 32'(receiver_send_acks), 32'h0);
        end
        int_ack = 1'b1;
        receiver_sends = 4'b0010;
        cycle();
        chk("hold_release_valid", 32'(int_valid), 32'h0);
        chk("hold_release_acks", 32'(receiver_send_acks), 32'h0);
        int_ack = 1'b0;
        push(2'd1);
        n = 0;
        do begin
            cycle();
            n++;
        end while (receiver_send_acks == '0 && n < 8);
        chk("bus1_grant_latency", 32'(n), 32'd1);
        chk("bus1_grant_acks", 32'(receiver_send_acks), 32'h2);
        receiver_sends = '0;
        int_ack = 1'b1;
        cycle();
        int_ack = 1'b0;

        // A request withdrawn before int_enable rises is never acked.
        int_enable = 1'b0;
        receiver_sends = 4'b0100;
        cycle();
        int_enable = 1'b1;
        receiver_sends = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk($sformatf("withdrawn%0d_acks", c), 32'(receiver_send_acks), 32'h0);
            chk($sformatf("withdrawn%0d_valid", c), 32'(int_valid), 32'h0);
        end

        chk("sb_leftover", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
